// File: rtl/sseg_pkg.sv
// Shared definitions for the signed-binary to multiplexed seven-segment display path:
// converter FSM states, active-low glyph constants and the BCD nibble type.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Segment order is g,f,e,d,c,b,a with 0 meaning lit
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal power used to size the overflow threshold of the magnitude digits
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational glyph decoder: one BCD nibble plus blank/dash overrides to an
// active-low seven-segment pattern. Non-decimal nibbles decode to blank.
module bcd_to_sseg (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    import sseg_pkg::*;

    // Dash wins over blank, then plain decimal decode
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sseg_scan_bcd.sv
// Signed binary to multiplexed seven-segment display driver.
// A sequential double-dabble converter fills a display register that a free-running
// refresh divider scans one digit at a time. The leftmost digit carries the sign.
// Build option: define SSEG_LZB_EN to blank leading zeros and float the minus sign
// to the digit just left of the most significant nonzero digit.
module sseg_scan_bcd #(
    parameter int WIDTH   = 8,
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic              valid,
    output logic              busy,
    output logic [7:0]        ssegs,
    output logic [DIGITS-1:0] disp_en
);
    import sseg_pkg::*;

    localparam int BW = (DIGITS - 1) * 4;
    localparam int IW = $clog2(DIGITS);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(WIDTH);
    localparam logic [31:0] LIMIT = 32'(pow10(DIGITS - 1));

    state_t                state;
    logic [WIDTH-1:0]      val_q;
    logic                  sign_q;
    logic [WIDTH-1:0]      mag;
    logic [BW-1:0]         bcd;
    logic                  ovf_q;
    logic [SW-1:0]         shift_cnt;

    logic [BW-1:0]         disp_bcd;
    logic                  disp_sign;
    logic                  disp_ovf;

    logic [DW-1:0]         div_cnt;
    logic [IW-1:0]         idx;

    logic [WIDTH-1:0]      abs_val;
    logic [BW-1:0]         bcd_adj;
    logic [BW+WIDTH-1:0]   dd_next;

    bcd_t                  sel_nib;
    logic                  dig_blank;
    logic                  dig_dash;
    logic [6:0]            glyph;

    // Two's-complement magnitude; the most negative input maps to 2^(WIDTH-1) unsigned
    always_comb begin
        abs_val = val_q[WIDTH-1] ? (~val_q + WIDTH'(1)) : val_q;
    end

    // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        dd_next = {bcd_adj, mag} << 1;
    end

    // Converter FSM: capture, take magnitude, WIDTH shift steps, then publish to the display register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            val_q     <= '0;
            sign_q    <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            ovf_q     <= 1'b0;
            shift_cnt <= '0;
            disp_bcd  <= '0;
            disp_sign <= 1'b0;
            disp_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        val_q <= value;
                        busy  <= 1'b1;
                        state <= ABS;
                    end
                end
                ABS: begin
                    sign_q    <= val_q[WIDTH-1];
                    mag       <= abs_val;
                    ovf_q     <= (32'(abs_val) >= LIMIT);
                    bcd       <= '0;
                    shift_cnt <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    {bcd, mag} <= dd_next;
                    if (shift_cnt == SW'(WIDTH - 1)) begin
                        state <= DONE;
                    end else begin
                        shift_cnt <= shift_cnt + SW'(1);
                    end
                end
                DONE: begin
                    disp_bcd  <= bcd;
                    disp_sign <= sign_q;
                    disp_ovf  <= ovf_q;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refresh divider and digit index, independent of the converter and of valid
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Digit mux: pick the nibble for the scanned index and decide blank/dash overrides
    always_comb begin
`ifdef SSEG_LZB_EN
        int msd;
`endif
        sel_nib   = 4'd0;
        dig_blank = 1'b0;
        dig_dash  = 1'b0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (idx == IW'(i)) begin
                sel_nib = disp_bcd[i*4 +: 4];
            end
        end
`ifdef SSEG_LZB_EN
        msd = 0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (disp_bcd[i*4 +: 4] != 4'd0) begin
                msd = i;
            end
        end
        if (disp_ovf) begin
            dig_dash = 1'b1;
        end else if (int'(idx) > msd) begin
            if (disp_sign && (int'(idx) == msd + 1)) begin
                dig_dash = 1'b1;
            end else begin
                dig_blank = 1'b1;
            end
        end
`else
        if (disp_ovf) begin
            dig_dash = 1'b1;
        end else if (idx == IW'(DIGITS - 1)) begin
            if (disp_sign) begin
                dig_dash = 1'b1;
            end else begin
                dig_blank = 1'b1;
            end
        end
`endif
    end

    bcd_to_sseg u_dec (
        .digit (sel_nib),
        .blank (dig_blank),
        .dash  (dig_dash),
        .seg   (glyph)
    );

    // Registered display outputs; they follow the scanned digit one clock later
    always_ff @(posedge clk) begin
        if (rst) begin
            ssegs   <= 8'hFF;
            disp_en <= '1;
        end else if (valid) begin
            ssegs   <= {1'b1, glyph};
            disp_en <= ~(DIGITS'(1) << idx);
        end else begin
            ssegs   <= 8'hFF;
            disp_en <= '1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_bcd.sv
// Self-checking bench for sseg_scan_bcd at WIDTH=8, DIGITS=4, CLK_DIV=4.
// A decimal-arithmetic model predicts busy and the scanned outputs every cycle;
// directed scenarios add literal digit-by-digit expectations.
module tb_sseg_scan_bcd;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       load;
    logic       valid;
    logic       busy;
    logic [7:0] ssegs;
    logic [3:0] disp_en;

    int checksTotal  = 0;
    int checksPassed = 0;
    bit cmpOn        = 0;

    sseg_scan_bcd #(
        .WIDTH   (8),
        .DIGITS  (4),
        .CLK_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .valid   (valid),
        .busy    (busy),
        .ssegs   (ssegs),
        .disp_en (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int         mBusy    = 0;
    int         mCount   = 0;
    int         mPending = 0;
    int         mShown   = 0;
    int         mDiv     = 0;
    int         mIdx     = 0;
    logic [7:0] expSegs  = 8'hFF;
    logic [3:0] expEn    = 4'hF;
    logic       expBusy  = 1'b0;

    logic [7:0] digitGlyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] enPat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         p10 [4]   = '{1, 10, 100, 1000};

    function automatic logic [7:0] modelSeg(input int i, input int v);
        int mag;
        bit neg;
        int n;
        neg = (v < 0);
        mag = neg ? -v : v;
        if (mag >= 1000) return 8'hBF;
`ifdef SSEG_LZB_EN
        n = 1;
        for (int t = mag; t >= 10; t = t / 10) n++;
        if (i < n) return digitGlyph[(mag / p10[i]) % 10];
        if (i == n && neg) return 8'hBF;
        return 8'hFF;
`else
        n = 0;
        if (i == 3) return neg ? 8'hBF : 8'hFF;
        return digitGlyph[(mag / p10[i]) % 10 + n];
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [7:0] v, input logic vl, input logic r);
        @(negedge clk);
        load  = l;
        value = v;
        valid = vl;
        rst   = r;
    endtask

    // Model: outputs reflect the scan position and display value held before each edge
    always @(posedge clk) begin
        if (rst) begin
            mBusy   = 0;
            mDiv    = 0;
            mIdx    = 0;
            mShown  = 0;
            expSegs = 8'hFF;
            expEn   = 4'hF;
        end else begin
            if (valid) begin
                expSegs = modelSeg(mIdx, mShown);
                expEn   = enPat[mIdx];
            end else begin
                expSegs = 8'hFF;
                expEn   = 4'hF;
            end
            if (mBusy != 0) begin
                mCount++;
                if (mCount == 10) begin
                    mShown = mPending;
                    mBusy  = 0;
                end
            end else if (load) begin
                mPending = int'($signed(value));
                mBusy    = 1;
                mCount   = 0;
            end
            if (mDiv == 3) begin
                mDiv = 0;
                mIdx = (mIdx + 1) % 4;
            end else begin
                mDiv++;
            end
        end
        expBusy = (mBusy != 0);
    end

    // Compare process: every cycle once reset has been applied
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("busy", {7'b0, busy}, {7'b0, expBusy});
            checkOutput("ssegs", ssegs, expSegs);
            checkOutput("disp_en", {4'b0, disp_en}, {4'b0, expEn});
        end
    end

    task automatic waitDigit(input logic [3:0] pat, input logic [7:0] exp, input string name);
        bit found;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (disp_en === pat) begin
                found = 1;
                break;
            end
        end
        if (found) checkOutput(name, ssegs, exp);
        else checkOutput({name, " scan timeout"}, {4'b0, disp_en}, {4'b0, pat});
    endtask

    task automatic checkDisplay(input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0, input string tag);
        waitDigit(4'b1110, d0, {tag, " d0"});
        waitDigit(4'b1101, d1, {tag, " d1"});
        waitDigit(4'b1011, d2, {tag, " d2"});
        waitDigit(4'b0111, d3, {tag, " d3"});
    endtask

    // Load a value, optionally inject a second load while busy, and count busy cycles
    task automatic runConversion(input logic [7:0] v, input int injectAt,
                                 input logic [7:0] injVal, input string name);
        int cnt;
        applyStimulus(1'b1, v, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == injectAt) begin
                load  = 1'b1;
                value = injVal;
            end else begin
                load  = 1'b0;
                value = 8'h00;
            end
            if (busy === 1'b1) cnt++;
            else break;
        end
        checkOutput({name, " busy cycles"}, 8'(cnt), 8'd10);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 8'h00;
        valid = 1'b0;
        @(posedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cmpOn = 1;
        checkOutput("reset ssegs", ssegs, 8'hFF);
        checkOutput("reset disp_en", {4'b0, disp_en}, 8'h0F);
        checkOutput("reset busy", {7'b0, busy}, 8'h00);

        // Scan after reset: display register holds zero
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("first slot disp_en", {4'b0, disp_en}, 8'h0E);
        checkOutput("first slot ssegs", ssegs, 8'hC0);
`ifdef SSEG_LZB_EN
        checkDisplay(8'hFF, 8'hFF, 8'hFF, 8'hC0, "zero");
`else
        checkDisplay(8'hFF, 8'hC0, 8'hC0, 8'hC0, "zero");
`endif

        runConversion(8'h7B, -1, 8'h00, "123");
        checkDisplay(8'hFF, 8'hF9, 8'hA4, 8'hB0, "123");

        runConversion(8'h80, 3, 8'h05, "-128");
        checkDisplay(8'hBF, 8'hF9, 8'hA4, 8'h80, "-128");

        runConversion(8'hFF, -1, 8'h00, "-1");
`ifdef SSEG_LZB_EN
        checkDisplay(8'hFF, 8'hFF, 8'hBF, 8'hF9, "-1");
`else
        checkDisplay(8'hBF, 8'hC0, 8'hC0, 8'hF9, "-1");
`endif

        // Reset in the middle of a conversion, with a load presented alongside reset
        applyStimulus(1'b1, 8'h7B, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("abort busy", {7'b0, busy}, 8'h00);
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("abort stays idle", {7'b0, busy}, 8'h00);
`ifdef SSEG_LZB_EN
        checkDisplay(8'hFF, 8'hFF, 8'hFF, 8'hC0, "after abort");
`else
        checkDisplay(8'hFF, 8'hC0, 8'hC0, 8'hC0, "after abort");
`endif

        // Display disabled: all digit selects high while the scan keeps moving
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("valid0 disp_en", {4'b0, disp_en}, 8'h0F);
        checkOutput("valid0 ssegs", ssegs, 8'hFF);
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        runConversion(8'h2A, -1, 8'h00, "42");
`ifdef SSEG_LZB_EN
        checkDisplay(8'hFF, 8'hFF, 8'h99, 8'hA4, "42");
`else
        checkDisplay(8'hFF, 8'hC0, 8'h99, 8'hA4, "42");
`endif

        @(negedge clk);
        cmpOn = 0;
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/sseg_scan_bcd.md
SSEG_SCAN_BCD -- requirements
Module: sseg_scan_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the signed two's-complement input, legal range 2..16.
REQ-002 SHALL have parameter DIGITS, default 4: number of multiplexed display digits, legal range 2..8.
REQ-003 SHALL have parameter CLK_DIV, default 100000: clock cycles per digit refresh slot, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port value, input, WIDTH bits: signed two's-complement operand.
REQ-007 SHALL have port load, input, 1 bit: conversion request for value, sampled at the clock edge.
REQ-008 SHALL have port valid, input, 1 bit: display enable; 0 blanks every digit.
REQ-009 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 SHALL have port ssegs, output, 8 bits, active low: bit 7 is dp; bits 6:0 are segments g,f,e,d,c,b,a.
REQ-011 SHALL have port disp_en, output, DIGITS bits, active low one-hot digit select; bit 0 is the rightmost digit.

Function
REQ-012 FSM states SHALL be IDLE, ABS, SHIFT and DONE.
REQ-013 In IDLE, load=1 SHALL capture value, go to ABS, and raise busy on the next cycle.
REQ-014 ABS SHALL take one cycle and produce sign = value[WIDTH-1] and an unsigned WIDTH-bit magnitude; -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1) with no overflow.
REQ-015 SHALL run WIDTH cycles of sequential double-dabble (add-3-if-≥5 per BCD nibble, then shift) producing DIGITS-1 BCD digits.
REQ-016 DONE SHALL take one cycle: copy BCD digits and sign into the display register, clear busy, and return to IDLE.
REQ-017 Latency SHALL be WIDTH+2 cycles from the load edge to the display register update.
REQ-018 load while busy SHALL be ignored, with no queuing.
REQ-019 If the magnitude is ≥ 10^(DIGITS-1), the display register SHALL be set to all digits showing '-' (segment g only).
REQ-020 The sign digit is the leftmost digit (index DIGITS-1): '-' when sign=1, blank when sign=0.
REQ-021 Magnitude digits SHALL occupy indices DIGITS-2..0 and show hex-free decimal glyphs 0-9.
REQ-022 The refresh divider SHALL count 0..CLK_DIV-1; on the terminal count, the digit index SHALL advance modulo DIGITS (DIGITS-1 wraps to 0).
REQ-023 disp_en SHALL drive low only the bit for the current digit index when valid=1, and all ones when valid=0.
REQ-024 dp (ssegs[7]) SHALL be 1 (off) at all times.
REQ-025 Scanning SHALL continue uninterrupted during conversion, so the old value is displayed until DONE.

Reset
REQ-026 rst SHALL force state IDLE, busy=0, divider=0, digit index=0, display register=0 (magnitude 0, sign 0), ssegs=8'hFF and disp_en all ones, on the same edge.
REQ-027 rst asserted mid-conversion SHALL abandon the conversion; load sampled together with rst SHALL be ignored.

Configuration
REQ-028 SSEG_LZB_EN defined SHALL blank leading zero magnitude digits (not digit 0), and SHALL show '-' in the digit immediately left of the most significant nonzero digit, leaving the leftmost digit blank.
REQ-029 SSEG_LZB_EN undefined SHALL show all magnitude digits including leading zeros, with the sign in the leftmost digit.

Structure
REQ-030 A shared package sseg_pkg SHALL hold the FSM state enum, the active-low glyph constants (0-9, '-', blank) and a BCD-nibble typedef.
REQ-031 The sub-module bcd_to_sseg SHALL provide a combinational 4-bit BCD plus blank/dash flags to 7-bit glyph decode, and SHALL be instantiated once after the digit mux.

Verification (WIDTH=8, DIGITS=4, CLK_DIV=4)
REQ-032 Reset, then valid=1 -> digit 0 shows 8'hC0 ('0'), and disp_en cycles 1110,1101,1011,0111 every 4 clocks.
REQ-033 load with value=8'h7B (123) -> busy high for cycles 1..10, display updates at cycle 10 with digits blank,1,2,3.
REQ-034 load with value=8'h80 (-128) -> display '-',1,2,8; load during busy with value=5 -> ignored, display stays -128.
REQ-035 load with value=8'hFF (-1): with SSEG_LZB_EN -> blank,blank,'-',1; without it -> '-',0,0,1.
REQ-036 rst at cycle 5 of a conversion -> busy=0 on the next cycle, display 0, and no update at cycle 10.
REQ-037 valid=0 -> disp_en=1111 for all cycles; divider still advances, so the index resumes in sequence when valid returns to 1.
